// File: rtl/data_memory_responder_pkg.sv
// Shared constants for the data memory responder: RISC-V load/store width
// codes, FSM state encoding and default geometry/timing.
package data_memory_responder_pkg;

  localparam int DEFAULT_DEPTH_WORDS = 256;
  localparam int DEFAULT_WAIT_STATES = 2;

  localparam logic [2:0] F3_BYTE   = 3'b000;
  localparam logic [2:0] F3_HALF   = 3'b001;
  localparam logic [2:0] F3_WORD   = 3'b010;
  localparam logic [2:0] F3_BYTE_U = 3'b100;
  localparam logic [2:0] F3_HALF_U = 3'b101;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_RESPOND = 2'd2;

  // True when the width code is unusable for this direction or the byte
  // offset breaks natural alignment; address range is checked separately.
  function automatic logic access_illegal(input logic       write,
                                          input logic [2:0] funct3,
                                          input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    case (funct3)
      F3_BYTE:              bad = 1'b0;
      F3_HALF:              bad = offset[0];
      F3_WORD:              bad = (offset != 2'b00);
      F3_BYTE_U:            bad = write;
      F3_HALF_U:            bad = write | offset[0];
      default:              bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/data_memory_responder_load_store_aligner.sv
// Byte-lane steering between a 32-bit storage word and the right-aligned
// load/store data, with sign/zero extension and partial-word store merge.
module load_store_aligner
  import data_memory_responder_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word_in,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  assign lane_byte = word_in[{offset, 3'b000} +: 8];
  assign lane_half = word_in[{offset[1], 4'b0000} +: 16];

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    load_data = '0;
    case (funct3)
      F3_BYTE:   load_data = {{24{lane_byte[7]}}, lane_byte};
      F3_HALF:   load_data = {{16{lane_half[15]}}, lane_half};
      F3_WORD:   load_data = word_in;
      F3_BYTE_U: load_data = {24'h0, lane_byte};
      F3_HALF_U: load_data = {16'h0, lane_half};
      default:   load_data = '0;
    endcase
  end

  // Store merge keeps the untouched lanes of the current word.
  always_comb begin
    store_word = word_in;
    case (funct3)
      F3_BYTE: store_word[{offset, 3'b000} +: 8]     = store_data[7:0];
      F3_HALF: store_word[{offset[1], 4'b0000} +: 16] = store_data[15:0];
      F3_WORD: store_word = store_data;
      default: store_word = word_in;
    endcase
  end

endmodule

// File: rtl/data_memory_responder.sv
// Wait-stated data memory responder: accepts one load/store at a time,
// commits it on entry to RESPOND and holds the response until consumed.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int WAIT_STATES = DEFAULT_WAIT_STATES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [31:0] reqAddress,
  input  logic [31:0] reqWriteData,
  input  logic [2:0]  reqFunct3,
  output logic        respValid,
  input  logic        respReady,
  output logic [31:0] respReadData,
  output logic        respError
);

  localparam int         AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  logic [1:0]  state;
  logic [3:0]  counter;
  logic        lat_write;
  logic [31:0] lat_address;
  logic [31:0] lat_write_data;
  logic [2:0]  lat_funct3;
  logic [31:0] resp_data;
  logic        resp_error;
  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        enter_respond;
  logic        acc_write;
  logic [31:0] acc_address;
  logic [31:0] acc_write_data;
  logic [2:0]  acc_funct3;
  logic        acc_error;
  logic [AW-1:0] mem_index;
  logic [31:0] word_in;
  logic [31:0] load_data;
  logic [31:0] store_word;

  assign reqReady     = (state == ST_IDLE);
  assign respValid    = (state == ST_RESPOND);
  assign respReadData = resp_data;
  assign respError    = resp_error;
  assign accept       = reqValid && (state == ST_IDLE);

  assign enter_respond = (accept && (WAIT_STATES == 0)) ||
                         ((state == ST_WAIT) && (counter == 4'd0));

  // With no wait states the access happens on the accept edge itself, so the
  // live request is used; otherwise the latched copy.
  always_comb begin
    if (state == ST_IDLE) begin
      acc_write      = reqWrite;
      acc_address    = reqAddress;
      acc_write_data = reqWriteData;
      acc_funct3     = reqFunct3;
    end else begin
      acc_write      = lat_write;
      acc_address    = lat_address;
      acc_write_data = lat_write_data;
      acc_funct3     = lat_funct3;
    end
  end

  assign acc_error = ({2'b00, acc_address[31:2]} >= 32'(DEPTH_WORDS)) ||
                     access_illegal(acc_write, acc_funct3, acc_address[1:0]);
  assign mem_index = acc_error ? '0 : acc_address[AW+1:2];
  assign word_in   = mem[mem_index];

  load_store_aligner u_aligner (
    .funct3     (acc_funct3),
    .offset     (acc_address[1:0]),
    .word_in    (word_in),
    .store_data (acc_write_data),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      counter        <= 4'd0;
      lat_write      <= 1'b0;
      lat_address    <= '0;
      lat_write_data <= '0;
      lat_funct3     <= '0;
      resp_data      <= '0;
      resp_error     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            lat_write      <= reqWrite;
            lat_address    <= reqAddress;
            lat_write_data <= reqWriteData;
            lat_funct3     <= reqFunct3;
            if (WAIT_STATES == 0) begin
              state <= ST_RESPOND;
            end else begin
              state   <= ST_WAIT;
              counter <= WAIT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (counter == 4'd0) state <= ST_RESPOND;
          else                 counter <= counter - 4'd1;
        end
        ST_RESPOND: begin
          if (respReady) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (enter_respond) begin
        resp_error <= acc_error;
        resp_data  <= (acc_error || acc_write) ? 32'h0 : load_data;
      end
    end
  end

  // NOTE: storage is deliberately cleared by reset, which rules out a RAM
  // macro; a reset-less array would be the choice if that clear were dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (enter_respond && acc_write && !acc_error) begin
      mem[mem_index] <= store_word;
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Randomized self-checking bench for data_memory_responder against a
// byte-addressed reference model.
module tb_data_memory_responder;

  localparam int DEPTH = 256;
  localparam int WS    = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        reqValid, reqReady, reqWrite;
  logic [31:0] reqAddress, reqWriteData;
  logic [2:0]  reqFunct3;
  logic        respValid, respReady, respError;
  logic [31:0] respReadData;

  int errors = 0;
  int checks = 0;
  logic [7:0] model_bytes [4*DEPTH];

  data_memory_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clock        (clock),
    .reset        (reset),
    .reqValid     (reqValid),
    .reqReady     (reqReady),
    .reqWrite     (reqWrite),
    .reqAddress   (reqAddress),
    .reqWriteData (reqWriteData),
    .reqFunct3    (reqFunct3),
    .respValid    (respValid),
    .respReady    (respReady),
    .respReadData (respReadData),
    .respError    (respError)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4*DEPTH; i++) model_bytes[i] = 8'h00;
  endtask

  // Applies a request to the byte model and returns the expected response.
  task automatic model_access(input logic w, input logic [31:0] a, input logic [31:0] wd,
                              input logic [2:0] f3, output logic [31:0] data, output logic err);
    int size;
    logic [31:0] v;
    err = (f3 == 3) || (f3 >= 6) || (w && f3 >= 4) ||
          ((f3 == 1 || f3 == 5) && (a % 2 != 0)) ||
          ((f3 == 2) && (a % 4 != 0)) || ((a / 4) >= DEPTH);
    size = 1 << (f3 & 3'd3);
    data = 32'h0;
    if (!err) begin
      if (w) begin
        for (int i = 0; i < size; i++) model_bytes[a + i] = 8'(wd >> (8 * i));
      end else begin
        v = 32'h0;
        for (int i = 0; i < size; i++) v = v | (32'(model_bytes[a + i]) << (8 * i));
        if (f3 < 4 && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
        data = v;
      end
    end
  endtask

  // Issues one request from IDLE (called #1 after a rising edge) and checks
  // latency, response value, stall stability and the return to IDLE.
  task automatic transact(input logic w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] f3, input int stall, input bit noise);
    logic [31:0] exp_d, held_d;
    logic        exp_e, held_e;
    int          lat;
    model_access(w, a, wd, f3, exp_d, exp_e);
    check("req_ready_idle", 32'(reqReady), 32'd1);
    reqValid = 1'b1; reqWrite = w; reqAddress = a; reqWriteData = wd; reqFunct3 = f3;
    @(posedge clock); #1;
    reqValid = 1'b0; reqWrite = 1'b1; reqAddress = 32'h10;
    reqWriteData = $urandom; reqFunct3 = 3'b010;
    lat = 1;
    while (!respValid && lat < 20) begin
      check("req_ready_busy", 32'(reqReady), 32'd0);
      reqValid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clock); #1;
      lat++;
    end
    reqValid = 1'b0;
    check("latency", 32'(lat), 32'(WS + 1));
    check("resp_data", respReadData, exp_d);
    check("resp_error", 32'(respError), 32'(exp_e));
    held_d = respReadData;
    held_e = respError;
    for (int i = 0; i < stall; i++) begin
      reqValid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clock); #1;
      check("stall_valid", 32'(respValid), 32'd1);
      check("stall_data", respReadData, held_d);
      check("stall_error", 32'(respError), 32'(held_e));
      check("stall_req_ready", 32'(reqReady), 32'd0);
    end
    reqValid = 1'b0;
    respReady = 1'b1;
    @(posedge clock); #1;
    respReady = 1'b0;
    check("resp_valid_drop", 32'(respValid), 32'd0);
    check("req_ready_back", 32'(reqReady), 32'd1);
  endtask

  initial begin
    logic [31:0] a;
    reset = 1'b1; reqValid = 1'b0; reqWrite = 1'b0; reqAddress = '0;
    reqWriteData = '0; reqFunct3 = '0; respReady = 1'b0;
    model_clear();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    check("rst_req_ready", 32'(reqReady), 32'd1);
    check("rst_resp_valid", 32'(respValid), 32'd0);
    check("rst_resp_data", respReadData, 32'h0);
    check("rst_resp_error", 32'(respError), 32'd0);

    // Directed: word store/load, lane extraction and sign handling.
    transact(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 0, 1'b0);
    transact(1'b0, 32'h10, 32'h0, 3'b010, 0, 1'b0);
    transact(1'b0, 32'h13, 32'h0, 3'b000, 0, 1'b0);
    transact(1'b0, 32'h13, 32'h0, 3'b100, 0, 1'b0);
    transact(1'b0, 32'h12, 32'h0, 3'b001, 0, 1'b0);
    transact(1'b0, 32'h10, 32'h0, 3'b101, 0, 1'b0);
    check("lb_const", {24'hFFFFFF, model_bytes[8'h13]}, 32'hFFFFFFDE);
    transact(1'b1, 32'h11, 32'h55, 3'b000, 0, 1'b0);
    transact(1'b0, 32'h10, 32'h0, 3'b010, 0, 1'b0);
    check("sb_merge_const", {model_bytes[8'h13], model_bytes[8'h12], model_bytes[8'h11],
                             model_bytes[8'h10]}, 32'hDEAD55EF);

    // Rejected requests, then proof that storage is untouched.
    transact(1'b0, 32'h12, 32'h0, 3'b010, 0, 1'b0);
    transact(1'b1, 32'h03, 32'hFFFF, 3'b001, 0, 1'b0);
    transact(1'b0, 32'(4 * DEPTH), 32'h0, 3'b010, 0, 1'b0);
    transact(1'b1, 32'h10, 32'h1234, 3'b101, 0, 1'b0);
    transact(1'b0, 32'h10, 32'h0, 3'b011, 0, 1'b0);
    transact(1'b0, 32'h00, 32'h0, 3'b010, 0, 1'b0);
    transact(1'b0, 32'h10, 32'h0, 3'b010, 0, 1'b0);

    // Long stall with request noise during WAIT/RESPOND.
    transact(1'b0, 32'h10, 32'h0, 3'b010, 5, 1'b1);
    transact(1'b1, 32'h14, 32'hCAFEF00D, 3'b010, 5, 1'b1);
    transact(1'b0, 32'h10, 32'h0, 3'b010, 0, 1'b0);

    // Reset during WAIT discards the in-flight store.
    reqValid = 1'b1; reqWrite = 1'b1; reqAddress = 32'h20;
    reqWriteData = 32'h12345678; reqFunct3 = 3'b010;
    @(posedge clock); #1;
    reqValid = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    model_clear();
    check("wait_rst_valid", 32'(respValid), 32'd0);
    check("wait_rst_idle", 32'(reqReady), 32'd1);
    transact(1'b0, 32'h20, 32'h0, 3'b010, 0, 1'b0);
    transact(1'b0, 32'h10, 32'h0, 3'b010, 0, 1'b0);

    // Randomized traffic over a small window plus occasional out-of-range.
    for (int n = 0; n < 80; n++) begin
      a = ($urandom_range(0, 15) == 0) ? 32'(4 * DEPTH) + 32'($urandom_range(0, 7))
                                        : 32'($urandom_range(0, 63));
      transact(1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)),
               $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 64; i += 4) transact(1'b0, 32'(i), 32'h0, 3'b010, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit storage words.
REQ-002 SHALL have parameter WAIT_STATES, default 2, meaning the access delay in cycles (0..15).
REQ-003 SHALL have port clock  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port reqValid  input  1  initiator presents a request.
REQ-006 SHALL have port reqReady  output  1  responder accepts a request this cycle.
REQ-007 SHALL have port reqWrite  input  1  1 = store, 0 = load.
REQ-008 SHALL have port reqAddress  input  32  byte address.
REQ-009 SHALL have port reqWriteData  input  32  store data, right-aligned.
REQ-010 SHALL have port reqFunct3  input  3  RISC-V load/store width code.
REQ-011 SHALL have port respValid  output  1  response available.
REQ-012 SHALL have port respReady  input  1  initiator consumes the response.
REQ-013 SHALL have port respReadData  output  32  load result, extended to 32 bits.
REQ-014 SHALL have port respError  output  1  request was rejected (misaligned, out of range or illegal).

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESPOND.
REQ-016 SHALL drive reqReady=1 only in IDLE, and SHALL accept a request on reqValid&&reqReady by latching reqWrite, reqAddress, reqWriteData and reqFunct3.
REQ-017 SHALL transition IDLE->WAIT on accept when WAIT_STATES>0, and SHALL load a counter with WAIT_STATES-1.
REQ-018 SHALL transition IDLE->RESPOND directly on accept when WAIT_STATES=0.
REQ-019 SHALL decrement the counter once per cycle in WAIT, and SHALL go to RESPOND when the counter reaches 0; total accept-to-respValid latency is WAIT_STATES+1 cycles.
REQ-020 SHALL perform the access (store commit or load capture) exactly once, on the edge that enters RESPOND.
REQ-021 SHALL hold respValid=1, respReadData and respError stable in RESPOND until respReady=1.
REQ-022 SHALL return RESPOND->IDLE on respReady=1, with reqReady=1 on the following cycle; there is no same-cycle back-to-back accept.
REQ-023 SHALL ignore requests outside IDLE; reqValid changes in WAIT/RESPOND have no effect.
REQ-024 SHALL decode loads as 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, and stores as 000 SB, 001 SH, 010 SW.
REQ-025 SHALL sign-extend LB/LH results and zero-extend LBU/LHU results.
REQ-026 SHALL use little-endian byte lanes selected by address[1:0]; SB/SH modify only the addressed bytes.
REQ-027 SHALL flag respError=1, with no storage change and respReadData=0, for any of:
  - a halfword access with address[0]=1;
  - a word access with address[1:0]!=0;
  - address[31:2]>=DEPTH_WORDS;
  - funct3 in {011,110,111};
  - a store with funct3 in {100,101}.
REQ-028 SHALL drive respReadData=0 for every store response.

Reset
REQ-029 SHALL, on reset, force state IDLE, counter 0, reqReady=1 on the first cycle after reset, respValid=0, respReadData=0, respError=0.
REQ-030 SHALL clear all storage words to 0 on reset.
REQ-031 SHALL discard any in-flight request on reset asserted during WAIT, with no store committed.
REQ-032 SHALL discard a pending response on reset asserted during RESPOND; a store already committed remains overwritten only by the REQ-030 clear.
REQ-033 SHALL give reset priority over every other event in the same cycle, including accept and respReady.

Structure
REQ-034 SHALL place the funct3 width constants, FSM state encoding and the default DEPTH_WORDS/WAIT_STATES values in a shared package.
REQ-035 SHALL implement byte-lane extraction, sign/zero extension and store merge in one sub-module, load_store_aligner.
REQ-036 SHALL implement storage as a DEPTH_WORDS x 32 register array indexed by address[31:2].

Verification
REQ-037 SHALL cover: SW 0xDEADBEEF @0x10, then LW @0x10 -> respReadData=0xDEADBEEF, respError=0, respValid 3 cycles after each accept (WAIT_STATES=2).
REQ-038 SHALL cover: after REQ-037 state, LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; LHU @0x10 -> 0x0000BEEF.
REQ-039 SHALL cover: SB 0x55 @0x11, then LW @0x10 -> 0xDEAD55EF.
REQ-040 SHALL cover: LW @0x12, SH @0x03, and LW @(4*DEPTH_WORDS) -> respError=1, respReadData=0, storage unchanged.
REQ-041 SHALL cover: respReady held 0 for 5 cycles in RESPOND -> respValid/respReadData stable, reqReady=0; reqValid pulses during WAIT are ignored.
REQ-042 SHALL cover: SW 0x12345678 @0x20 with reset asserted in WAIT -> respValid=0 next cycle, state IDLE; a subsequent LW @0x20 -> 0x00000000.
